// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub: the operand beat on the input side,
// the result and flags on the output side. The master drives operands; the slave is the adder.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, carryin, sub, out_ready,
    input  in_ready, out_valid, sum, carryout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, carryin, sub, out_ready,
    output in_ready, out_valid, sum, carryout, overflow, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage, carry registered between stages.
// Define PIPELINED_ADDSUB_SATURATE_EN to clamp the result on signed overflow.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_addsub_if.slave bus_io
);
  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic             adv;
  logic             vld_d;
  logic             cout_d;
  logic             ovf_d;
  logic [WIDTH-1:0] res_d;

  logic             out_v_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [WIDTH-1:0] sum_q;

  // A single stall signal freezes every stage, bubbles included.
  assign adv             = !out_v_q || bus_io.out_ready;
  assign bus_io.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // R: operand bits not yet consumed on entry; L: sum bits already resolved on entry.
    localparam int unsigned R = WIDTH - k * CHUNK;
    localparam int unsigned L = k * CHUNK;

    logic               v_in;
    logic               c_in;
    logic [R-1:0]       a_in;
    logic [R-1:0]       b_in;
    logic [CHUNK:0]     part;
    logic [L+CHUNK-1:0] s_full;

    assign part = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

    if (k == 0) begin : g_head
      assign v_in   = bus_io.in_valid;
      assign a_in   = bus_io.a;
      assign b_in   = bus_io.sub ? ~bus_io.b : bus_io.b;
      assign c_in   = bus_io.sub | bus_io.carryin;
      assign s_full = part[CHUNK-1:0];
    end else begin : g_body
      assign v_in   = g_stage[k-1].g_mid.v_q;
      assign a_in   = g_stage[k-1].g_mid.a_q;
      assign b_in   = g_stage[k-1].g_mid.b_q;
      assign c_in   = g_stage[k-1].g_mid.c_q;
      assign s_full = {part[CHUNK-1:0], g_stage[k-1].g_mid.s_q};
    end

    if (k < STAGES - 1) begin : g_mid
      logic               v_q;
      logic               c_q;
      logic [R-CHUNK-1:0] a_q;
      logic [R-CHUNK-1:0] b_q;
      logic [L+CHUNK-1:0] s_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
        end else if (adv) begin
          v_q <= v_in;
          if (v_in) begin
            c_q <= part[CHUNK];
            a_q <= a_in[R-1:CHUNK];
            b_q <= b_in[R-1:CHUNK];
            s_q <= s_full;
          end
        end
      end
    end else begin : g_tail
      // Same-sign operands producing an opposite-sign sum is signed overflow.
      assign ovf_d  = (a_in[R-1] == b_in[R-1]) && (s_full[WIDTH-1] != a_in[R-1]);
      assign vld_d  = v_in;
      assign cout_d = part[CHUNK];
`ifdef PIPELINED_ADDSUB_SATURATE_EN
      assign res_d  = !ovf_d     ? s_full :
                      a_in[R-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                  {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign res_d  = s_full;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      out_v_q <= vld_d;
      if (vld_d) begin
        sum_q  <= res_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= ~|res_d;
      end
    end
  end

  assign bus_io.out_valid = out_v_q;
  assign bus_io.sum       = sum_q;
  assign bus_io.carryout  = cout_q;
  assign bus_io.overflow  = ovf_q;
  assign bus_io.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=16, CHUNK=4): latency, wrap, overflow,
// streaming, backpressure and mid-flight reset, with hand-computed expectations.
module tb_pipelined_addsub;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   sent;
  int   rcvd;
  logic stall;
  logic acc;

`ifdef PIPELINED_ADDSUB_SATURATE_EN
  localparam logic [15:0] SubOvfSum = 16'h8000;
  localparam logic [15:0] AddOvfSum = 16'h7FFF;
`else
  localparam logic [15:0] SubOvfSum = 16'h7FFF;
  localparam logic [15:0] AddOvfSum = 16'h8000;
`endif

  pipelined_addsub_if #(.WIDTH(16)) bus ();

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic s, input logic [15:0] es,
                         input logic ec, input logic eo, input logic ez);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.carryin  = cin;
    bus.sub      = s;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk({tag, " early_valid"}, bus.out_valid, 1'b0);
    tick();
    chk({tag, " valid"}, bus.out_valid, 1'b1);
    chk({tag, " sum"}, bus.sum, es);
    chk({tag, " carryout"}, bus.carryout, ec);
    chk({tag, " overflow"}, bus.overflow, eo);
    chk({tag, " zero"}, bus.zero, ez);
    tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.carryin   = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset sum", bus.sum, 16'h0000);
    chk("reset carryout", bus.carryout, 1'b0);
    chk("reset overflow", bus.overflow, 1'b0);
    chk("reset zero", bus.zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", bus.in_ready, 1'b1);
    tick();

    run_one("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, SubOvfSum, 1'b1, 1'b1, 1'b0);
    run_one("carry_chain", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    run_one("add_ovf_cin", 16'h7FFF, 16'h0000, 1'b1, 1'b0, AddOvfSum, 1'b0, 1'b1, 1'b0);
    run_one("sub_equal", 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_one("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Streaming: eight back-to-back beats, results on eight consecutive cycles.
    for (int t = 0; t < 12; t++) begin
      bus.in_valid = (t < 8);
      bus.a        = 16'(t);
      bus.b        = 16'(t * 16'h0100);
      bus.carryin  = 1'b0;
      bus.sub      = 1'b0;
      chk("stream in_ready", bus.in_ready, 1'b1);
      tick();
      chk("stream valid", bus.out_valid, (t >= 3 && t <= 10));
      if (t >= 3 && t <= 10) chk("stream sum", bus.sum, 16'((t - 3) * 16'h0101));
    end
    bus.in_valid = 1'b0;
    tick();

    // Backpressure: six beats with the sink stalled for four cycles.
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 30 && rcvd < 6; c++) begin
      stall         = (c >= 5 && c <= 8);
      bus.out_ready = !stall;
      bus.in_valid  = (sent < 6);
      bus.a         = 16'(sent);
      bus.b         = 16'h0200;
      #1;
      if (stall) begin
        chk("bp in_ready", bus.in_ready, 1'b0);
        chk("bp valid_held", bus.out_valid, 1'b1);
      end
      if (bus.out_valid) begin
        chk("bp sum_order", bus.sum, 16'(16'h0200 + rcvd));
        if (bus.out_ready) rcvd++;
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) sent++;
    end
    chk("bp sent", sent, 6);
    chk("bp received", rcvd, 6);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp no_dup", bus.out_valid, 1'b0);
    tick();

    // Mid-flight reset: three beats in the pipe, first one at the output.
    for (int j = 0; j < 3; j++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'((j + 1) * 16'h1000);
      bus.b        = 16'h0234;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("rst pre_valid", bus.out_valid, 1'b1);
    chk("rst pre_sum", bus.sum, 16'h1234);
    rst_n = 1'b0;
    #2;
    chk("rst async_valid", bus.out_valid, 1'b0);
    chk("rst async_sum", bus.sum, 16'h0000);
    chk("rst async_carry", bus.carryout, 1'b0);
    chk("rst async_zero", bus.zero, 1'b0);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("rst flushed", bus.out_valid, 1'b0);
    end
    run_one("post_reset", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
